cp0_unit: RTL and testbench
===========================

// Module: cp0_unit
// PURPOSE
//  Coprocessor-0 exception/interrupt controller at the M stage of the 5-stage MIPS pipeline.
//  Collects the pipelined exception code and branch-delay flag from the stage registers.
//  Arbitrates them against external hardware interrupts and asserts req.
//  req makes every stage register flush and load the handler PC.
//  Holds SR/Cause/EPC/PRId and services mtc0, mfc0 and eret.
// PARAMETERS
//  PRID          32'h2020_0001  read-only value of PRId (reg 15)
//  HANDLER_ADDR  32'h0000_4180  exception vector; the stage registers also use this value
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  M_pc        in   32  PC of the instruction in M
//  M_bd        in   1   M instruction sits in a branch-delay slot
//  M_exc       in   5   pipelined ExcCode; 0 = none
//  hw_int      in   6   external interrupt lines, level-sensitive
//  cp0_we      in   1   mtc0 commit in M
//  cp0_addr    in   5   CP0 register number for mtc0/mfc0
//  cp0_wdata   in   32  mtc0 data
//  eret        in   1   eret commit in M
//  cp0_rdata   out  32  mfc0 read data, combinational
//  epc_out     out  32  current EPC, eret target
//  req         out  1   flush-and-vector request, combinational
// BEHAVIOUR
//  Reset (async): SR=0 (IM=0, EXL=0, IE=0); Cause=0; EPC=0; so req=0 and epc_out=0.
//  SR fields: IM=[15:10], EXL=[1], IE=[0]; other bits read as 0.
//  Cause fields: BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read as 0.
//  Cause.IP <= hw_int every cycle, regardless of other events.
//  int_req = IE & ~EXL & |(IM & hw_int).
//  exc_req = ~EXL & (M_exc != 0).
//  req = int_req | exc_req. Interrupt has priority over exception.
//  Two states, driven by EXL: USER (EXL=0) and HANDLER (EXL=1).
//   USER->HANDLER on req; HANDLER->USER on eret, or on mtc0 SR with wdata[1]=0.
//   In HANDLER, req is held at 0: no nesting, and hw_int/M_exc are ignored.
//  On req, at the clock edge:
//   - EXL<=1; BD<=M_bd.
//   - ExcCode <= int_req ? 0 : M_exc.
//   - EPC <= (M_bd ? M_pc-32'd4 : M_pc) & ~32'h3.
//  req=1 in the same cycle as cp0_we: the write is dropped; the exception wins.
//  req=1 and eret in the same cycle is impossible: eret is only legal with EXL=1,
//   which blocks req. eret with EXL=0 clears nothing and gives no error.
//  mtc0 writable registers:
//   - SR (12): IM, EXL, IE.
//   - EPC (14): full word, stored & ~32'h3.
//   - Cause: not writable.
//   - Other addresses: ignored.
//  mfc0 returns SR/Cause/EPC/PRId per cp0_addr, else 0.
//   No write-to-read bypass: it returns the pre-edge value.
//  epc_out = EPC register; the pipeline uses it as the eret target PC.
//  req is 1-cycle combinational.
//  Reset mid-handler: all state clears at once; req drops asynchronously.
// CONFIGURATION
//  CP0_BADVADDR_EN defined:
//   - Adds input bad_vaddr[31:0] and register BadVAddr (8), reset 0, read-only via mfc0.
//   - Loads bad_vaddr on exc_req with M_exc==4 (AdEL) or 5 (AdES), and not int_req.
//  Undefined: no port and no register; address 8 reads 0.
// STRUCTURE
//  cp0_pkg:
//   - Register numbers SR=12, CAUSE=13, EPC=14, PRID=15, BADVADDR=8.
//   - ExcCode constants INT=0, ADEL=4, ADES=5, RI=10, OV=12.
//   - SR/Cause field bit positions.
//  Sub-module cp0_req_arbiter (combinational): SR, hw_int, M_exc -> int_req, exc_req, code.
//  Register file and FSM stay in cp0_unit.
// TESTING
//  1 SR=0x0000_0401, hw_int=6'b000001, M_pc=0x3010, M_bd=0 -> req=1 for one cycle;
//    then Cause=0x0000_0400 (ExcCode 0), EPC=0x3010, EXL=1.
//  2 EXL=0, M_exc=12, M_bd=1, M_pc=0x3024 -> req=1;
//    Cause[31]=1, ExcCode=12, EPC=0x3020.
//  3 In HANDLER, M_exc=10 and hw_int=6'h3F -> req stays 0; Cause.IP=6'h3F; EPC unchanged.
//    Then eret -> EXL=0 next cycle.
//  4 cp0_we=1, cp0_addr=12, wdata=0x0000_FC01 with M_exc=4 in the same cycle -> req=1;
//    SR write dropped (IM unchanged), EXL=1.
//  5 mtc0 EPC 0x0000_3007 -> mfc0 14 returns 0x3004, epc_out=0x3004;
//    mfc0 15 returns PRID; mfc0 8 returns 0 with CP0_BADVADDR_EN undefined.
//  6 Assert reset asynchronously mid-cycle while in HANDLER with req pending ->
//    SR/Cause/EPC=0 immediately; req=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 exception/interrupt controller:
// CP0 register numbers, exception codes, SR/Cause field positions, the
// controller state type and helpers that assemble SR/Cause read words.
package cp0_pkg;

   // CP0 register numbers used by mtc0/mfc0
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_SR       = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_PRID     = 5'd15;

   // ExcCode values carried down the pipeline
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // SR field positions
   localparam int SR_IM_HI = 15;
   localparam int SR_IM_LO = 10;
   localparam int SR_EXL   = 1;
   localparam int SR_IE    = 0;

   // Cause field positions
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_EXC_LO = 2;

   // Controller state mirrors SR.EXL
   typedef enum logic {
      ST_USER    = 1'b0,
      ST_HANDLER = 1'b1
   } cp0_state_e;

   // Assemble the SR read word; unimplemented bits read as zero
   function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                           input logic       exl,
                                           input logic       ie);
      logic [31:0] r;
      r                     = '0;
      r[SR_IM_HI:SR_IM_LO]  = im;
      r[SR_EXL]             = exl;
      r[SR_IE]              = ie;
      return r;
   endfunction

   // Assemble the Cause read word; unimplemented bits read as zero
   function automatic logic [31:0] pack_cause(input logic       bd,
                                              input logic [5:0] ip,
                                              input logic [4:0] exc);
      logic [31:0] r;
      r                           = '0;
      r[CAUSE_BD]                 = bd;
      r[CAUSE_IP_HI:CAUSE_IP_LO]  = ip;
      r[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
      return r;
   endfunction

endpackage

// File: rtl/cp0_req_arbiter.sv
// Combinational arbitration of external interrupts against the pipelined
// exception code. Interrupts win; nothing is requested while EXL is set.
module cp0_req_arbiter
   import cp0_pkg::*;
(
   input  logic [5:0] sr_im,
   input  logic       sr_exl,
   input  logic       sr_ie,
   input  logic [5:0] hw_int,
   input  logic [4:0] m_exc,
   output logic       int_req,
   output logic       exc_req,
   output logic [4:0] code
);

   // Decide which event (if any) is taken and which ExcCode it records
   always_comb begin
      int_req = sr_ie & ~sr_exl & (|(sr_im & hw_int));
      exc_req = ~sr_exl & (m_exc != EXC_INT);
      code    = int_req ? EXC_INT : m_exc;
   end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller at the M stage. Holds
// SR/Cause/EPC/PRId, raises the flush-and-vector request and services
// mtc0, mfc0 and eret.
// Optional feature: define CP0_BADVADDR_EN to add the bad_vaddr input and
// the read-only BadVAddr register (CP0 reg 8).
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID         = 32'h2020_0001,
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] M_pc,
   input  logic        M_bd,
   input  logic [4:0]  M_exc,
   input  logic [5:0]  hw_int,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic        eret,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0] bad_vaddr,
`endif
   output logic [31:0] cp0_rdata,
   output logic [31:0] epc_out,
   output logic        req
);

   // The vector address is consumed by the stage registers; it is declared
   // here only so both sides are configured from one place.
   logic unused_handler_addr;
   assign unused_handler_addr = ^HANDLER_ADDR;

   cp0_state_e  state_q, state_d;
   logic [5:0]  im_q, im_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_q, badvaddr_d;
`endif

   logic        exl;
   logic        int_req;
   logic        exc_req;
   logic [4:0]  code;
   logic [31:0] epc_src;
   logic        wr_sr;
   logic        wr_epc;

   assign exl = (state_q == ST_HANDLER);

   cp0_req_arbiter u_arb (
      .sr_im   (im_q),
      .sr_exl  (exl),
      .sr_ie   (ie_q),
      .hw_int  (hw_int),
      .m_exc   (M_exc),
      .int_req (int_req),
      .exc_req (exc_req),
      .code    (code)
   );

   // Request is gated by reset so it drops the moment reset is asserted
   always_comb begin
      req     = ~reset & (int_req | exc_req);
      epc_out = epc_q;
      epc_src = (M_bd ? (M_pc - 32'd4) : M_pc) & ~32'h3;
      // a taken request drops any mtc0 committing in the same cycle
      wr_sr   = cp0_we & ~req & (cp0_addr == CP0_SR);
      wr_epc  = cp0_we & ~req & (cp0_addr == CP0_EPC);
   end

   // Next-state logic for the EXL state machine and the CP0 registers
   always_comb begin
      state_d   = state_q;
      im_d      = im_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      ip_d      = hw_int;
      exccode_d = exccode_q;
      epc_d     = epc_q;
`ifdef CP0_BADVADDR_EN
      badvaddr_d = badvaddr_q;
`endif

      case (state_q)
         ST_USER: begin
            if (req) begin
               state_d = ST_HANDLER;
            end else if (wr_sr) begin
               state_d = cp0_wdata[SR_EXL] ? ST_HANDLER : ST_USER;
            end
         end
         ST_HANDLER: begin
            if (eret) begin
               state_d = ST_USER;
            end else if (wr_sr) begin
               state_d = cp0_wdata[SR_EXL] ? ST_HANDLER : ST_USER;
            end
         end
         default: state_d = ST_USER;
      endcase

      if (req) begin
         bd_d      = M_bd;
         exccode_d = code;
         epc_d     = epc_src;
`ifdef CP0_BADVADDR_EN
         if (exc_req && !int_req && ((M_exc == EXC_ADEL) || (M_exc == EXC_ADES))) begin
            badvaddr_d = bad_vaddr;
         end
`endif
      end else begin
         if (wr_sr) begin
            im_d = cp0_wdata[SR_IM_HI:SR_IM_LO];
            ie_d = cp0_wdata[SR_IE];
         end
         if (wr_epc) begin
            epc_d = cp0_wdata & ~32'h3;
         end
      end
   end

   // CP0 state registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_USER;
         im_q      <= '0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ip_q      <= '0;
         exccode_q <= '0;
         epc_q     <= '0;
`ifdef CP0_BADVADDR_EN
         badvaddr_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         im_q      <= im_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         ip_q      <= ip_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
`ifdef CP0_BADVADDR_EN
         badvaddr_q <= badvaddr_d;
`endif
      end
   end

   // mfc0 read mux; returns pre-edge register contents
   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         CP0_SR:    cp0_rdata = pack_sr(im_q, exl, ie_q);
         CP0_CAUSE: cp0_rdata = pack_cause(bd_q, ip_q, exccode_q);
         CP0_EPC:   cp0_rdata = epc_q;
         CP0_PRID:  cp0_rdata = PRID;
`ifdef CP0_BADVADDR_EN
         CP0_BADVADDR: cp0_rdata = badvaddr_q;
`endif
         default:   cp0_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit (default build).
module tb_cp0_unit;

   localparam logic [31:0] PRID_V = 32'h2020_0001;

   logic        clk;
   logic        reset;
   logic [31:0] M_pc;
   logic        M_bd;
   logic [4:0]  M_exc;
   logic [5:0]  hw_int;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic        eret;
   logic [31:0] cp0_rdata;
   logic [31:0] epc_out;
   logic        req;

   int checks = 0;
   int errors = 0;

   cp0_unit #(
      .PRID         (PRID_V),
      .HANDLER_ADDR (32'h0000_4180)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .M_pc      (M_pc),
      .M_bd      (M_bd),
      .M_exc     (M_exc),
      .hw_int    (hw_int),
      .cp0_we    (cp0_we),
      .cp0_addr  (cp0_addr),
      .cp0_wdata (cp0_wdata),
      .eret      (eret),
      .cp0_rdata (cp0_rdata),
      .epc_out   (epc_out),
      .req       (req)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
      cp0_addr = a;
      #1;
      chk(cp0_rdata, exp, tag);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; M_pc = '0; M_bd = 1'b0; M_exc = '0; hw_int = '0;
      cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0; eret = 1'b0;
      #3;
      // reset state
      chk({31'b0, req}, 32'd0, "rst_req");
      chk(epc_out, 32'd0, "rst_epc_out");
      rd(5'd12, 32'h0, "rst_sr");
      rd(5'd13, 32'h0, "rst_cause");
      rd(5'd14, 32'h0, "rst_epc");
      rd(5'd15, PRID_V, "rst_prid");
      reset = 1'b0;
      tick;

      // 1: enable IM0/IE, raise hw_int[0]
      cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
      tick;
      cp0_we = 1'b0;
      rd(5'd12, 32'h0000_0401, "t1_sr_write");
      hw_int = 6'b000001; M_pc = 32'h3010;
      #1;
      chk({31'b0, req}, 32'd1, "t1_req");
      tick;
      chk({31'b0, req}, 32'd0, "t1_req_once");
      rd(5'd13, 32'h0000_0400, "t1_cause");
      rd(5'd14, 32'h0000_3010, "t1_epc");
      rd(5'd12, 32'h0000_0403, "t1_sr_exl");
      hw_int = 6'b0; eret = 1'b1;
      tick;
      eret = 1'b0;
      rd(5'd12, 32'h0000_0401, "t1_eret_sr");

      // 2: overflow in a delay slot
      M_exc = 5'd12; M_bd = 1'b1; M_pc = 32'h3024;
      #1;
      chk({31'b0, req}, 32'd1, "t2_req");
      tick;
      M_exc = 5'd0; M_bd = 1'b0;
      rd(5'd13, 32'h8000_0030, "t2_cause");
      rd(5'd14, 32'h0000_3020, "t2_epc");
      chk(epc_out, 32'h0000_3020, "t2_epc_out");

      // 3: events ignored in HANDLER, then eret
      M_exc = 5'd10; hw_int = 6'h3F;
      #1;
      chk({31'b0, req}, 32'd0, "t3_no_req");
      tick;
      rd(5'd13, 32'h8000_FC30, "t3_cause_ip");
      rd(5'd14, 32'h0000_3020, "t3_epc_kept");
      M_exc = 5'd0; hw_int = 6'h0; eret = 1'b1;
      tick;
      eret = 1'b0;
      rd(5'd12, 32'h0000_0401, "t3_eret_sr");

      // 4: mtc0 SR colliding with AdEL
      cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
      M_exc = 5'd4; M_pc = 32'h3040;
      #1;
      chk({31'b0, req}, 32'd1, "t4_req");
      tick;
      cp0_we = 1'b0; M_exc = 5'd0;
      rd(5'd12, 32'h0000_0403, "t4_sr_dropped");
      rd(5'd13, 32'h0000_0010, "t4_cause");
      rd(5'd14, 32'h0000_3040, "t4_epc");

      // 5: mtc0 EPC, mfc0 reads, unwritable Cause, leave HANDLER via mtc0 SR
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
      tick;
      cp0_we = 1'b0;
      rd(5'd14, 32'h0000_3004, "t5_epc");
      chk(epc_out, 32'h0000_3004, "t5_epc_out");
      rd(5'd15, PRID_V, "t5_prid");
      rd(5'd8, 32'h0, "t5_badvaddr");
      rd(5'd9, 32'h0, "t5_other");
      cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
      tick;
      cp0_we = 1'b0;
      rd(5'd13, 32'h0000_0010, "t5_cause_ro");
      cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0800;
      tick;
      cp0_we = 1'b0;
      rd(5'd12, 32'h0000_0800, "t5_sr_leave");
      eret = 1'b1;
      tick;
      eret = 1'b0;
      rd(5'd12, 32'h0000_0800, "t5_eret_user");
      rd(5'd14, 32'h0000_3004, "t5_eret_epc");
      hw_int = 6'b000010;
      #1;
      chk({31'b0, req}, 32'd0, "t5_ie_masked");
      hw_int = 6'b0;

      // 6: async reset while in HANDLER with an exception still presented
      M_exc = 5'd12; M_pc = 32'h3100;
      #1;
      chk({31'b0, req}, 32'd1, "t6_req");
      tick;
      rd(5'd12, 32'h0000_0802, "t6_sr_exl");
      hw_int = 6'h3F;
      #1;
      rd(5'd14, 32'h0000_3100, "t6_epc");
      reset = 1'b1;
      #1;
      chk({31'b0, req}, 32'd0, "t6_rst_req");
      rd(5'd12, 32'h0, "t6_rst_sr");
      rd(5'd13, 32'h0, "t6_rst_cause");
      rd(5'd14, 32'h0, "t6_rst_epc");
      chk(epc_out, 32'h0, "t6_rst_epc_out");
      M_exc = 5'd0; hw_int = 6'h0;
      tick;
      reset = 1'b0;
      tick;
      rd(5'd12, 32'h0, "t6_post_sr");
      chk({31'b0, req}, 32'd0, "t6_post_req");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
